bitwise_result_signature: RTL
=============================

Name: bitwise_result_signature

Overview:
Downstream consumer of the bitwise operation unit's registered result `q` and its `op` code. It compresses a programmed window of results into a MISR signature for self-check. It also accumulates a total ones count and a per-op sample histogram. It sits between the bitwise unit and the bench/host, which reads results after `done`.

Parameters:
WIDTH, 7, width of `q` and `signature`
CNT_W, 8, width of window length, sample counter and per-op counters
POLY, 7'b1100000, MISR feedback tap mask (x^7+x^6+1)
SEED, 7'b0000001, signature value loaded at start and at reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse, begins a capture window (honoured in IDLE only)
len  in  CNT_W  number of samples in window, sampled on accepted start
in_valid  in  1  `q`/`op` hold a result to absorb this cycle
q  in  WIDTH  result from bitwise unit
op  in  2  op code associated with `q`
busy  out  1  high in RUN
done  out  1  one-cycle pulse when window completes
signature  out  WIDTH  MISR value
sample_count  out  CNT_W  samples absorbed in current/last window
ones_total  out  CNT_W+3  sum of popcount(q) over window
op_count0..op_count3  out  CNT_W each  samples absorbed per op value

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, signature=SEED, sample_count=0, ones_total=0, op_count0..3=0, stored length=0.
- FSM states IDLE, RUN, DONE; all outputs registered.
- IDLE → RUN: on start=1 with len!=0.
  - Latch len.
  - Load signature=SEED; clear sample_count, ones_total, op_count0..3.
  - busy=1 from the next cycle.
  - in_valid in the same cycle as start is NOT absorbed.
- IDLE → DONE: on start=1 with len==0. Clear and SEED-load exactly as above; no samples absorbed.
- RUN absorb: each cycle with in_valid=1, in one cycle:
  - fb = XOR-reduce(signature & POLY).
  - signature <= ({signature[WIDTH-2:0], fb}) ^ q.
  - sample_count += 1.
  - ones_total += popcount(q), range 0..WIDTH.
  - op_count[op] += 1.
- RUN with in_valid=0: state held, nothing changes.
- RUN → DONE: in the cycle the absorbed sample makes sample_count == latched len. No further samples are absorbed.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE unconditionally.
- start handling outside IDLE:
  - start in RUN or DONE is ignored.
  - A new window needs start in IDLE, at the earliest one cycle after the done pulse.
- Result hold: all result outputs hold their values in IDLE until the next accepted start.
- Counter widths and wrap:
  - Per-op counters cannot overflow because len ≤ 2^CNT_W−1.
  - ones_total is sized for the worst case (7 × 255 = 1785 < 2^11); no saturation logic is required.
  - sample_count wraps never by construction.
- Latency: the result of sample N is reflected in the outputs one cycle after its in_valid cycle. done asserts one cycle after the last absorbed sample.
- Reset mid-RUN: immediate return to reset values; the partial window is discarded and no done pulse is produced.
- The value of `op` is used only when in_valid=1. X on q/op with in_valid=0 must not corrupt state.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release, no start → signature=0000001, all counters 0, busy=0, done=0 indefinitely.
- Single sample: start with len=1, next cycle in_valid=1, q=0000000, op=2 → signature=0000010, sample_count=1, ones_total=0, op_count2=1, then done pulse for one cycle.
- Two samples with gap: len=2; q=1111111 (op0), one cycle in_valid=0, then q=0000000 (op1) → intermediate signature 1111101, final 1111010, ones_total=7, op_count0=1, op_count1=1, done exactly once.
- Op histogram: len=5 with back-to-back valid, op sequence 0,1,2,3,0 and q = bitwise unit outputs from random a/b → op_count0=2, op_count1..3=1, sample_count=5; signature matches bench reference model.
- Boundaries: start with len=0 → done next cycle, signature=SEED, counters 0. start pulsed during RUN with len=9 → ignored, original window length kept. Extra in_valid after the last sample → not absorbed.
- Async reset mid-window: assert rst asynchronously after 3 of 10 samples → outputs immediately at reset values, no done. A restart with len=1 then completes normally.

Source files
------------

// File: rtl/bitwise_result_signature_if.sv
// Handshake/result bundle between the bitwise unit (plus its host) and the
// result signature block.
//   master : drives start/len/in_valid/q/op, observes the result outputs
//   slave  : the signature block itself
//   start, len        window control (start is honoured only while idle)
//   in_valid, q, op   one bitwise result per valid cycle
//   busy, done        window status (done is a one-cycle pulse)
//   signature         MISR compression of the window
//   sample_count      samples absorbed in the current/last window
//   ones_total        sum of popcount(q) over the window
//   op_count0..3      per-op sample histogram
interface bitwise_result_signature_if #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 8
) ();
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] q;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W+2:0] ones_total;
  logic [CNT_W-1:0] op_count0;
  logic [CNT_W-1:0] op_count1;
  logic [CNT_W-1:0] op_count2;
  logic [CNT_W-1:0] op_count3;

  modport master (
    output start, len, in_valid, q, op,
    input  busy, done, signature, sample_count, ones_total,
           op_count0, op_count1, op_count2, op_count3
  );

  modport slave (
    input  start, len, in_valid, q, op,
    output busy, done, signature, sample_count, ones_total,
           op_count0, op_count1, op_count2, op_count3
  );
endinterface

// File: rtl/bitwise_result_signature.sv
// Result signature block: compresses a programmed window of bitwise-unit
// results into a MISR signature, and accumulates a ones count and a per-op
// sample histogram. Every output is registered.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : bitwise_result_signature_if.slave (window control, result input,
//          status and result outputs)
module bitwise_result_signature #(
  parameter int               WIDTH = 7,
  parameter int               CNT_W = 8,
  parameter logic [WIDTH-1:0] POLY  = 7'b1100000,
  parameter logic [WIDTH-1:0] SEED  = 7'b0000001
) (
  input  logic                        clk,
  input  logic                        rst,
  bitwise_result_signature_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [WIDTH-1:0]           sig_q, sig_d;
  logic [CNT_W-1:0]           len_q, len_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CNT_W+2:0]           ones_q, ones_d;
  logic [3:0][CNT_W-1:0]      opc_q, opc_d;
  logic                       fb;

  function automatic logic [CNT_W+2:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W+2:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + (CNT_W+3)'(v[i]);
    return c;
  endfunction

  // MISR feedback taken from the tapped bits of the current signature.
  assign fb = ^(sig_q & POLY);

  always_comb begin
    // NOTE: every _d gets a default from its flop first, so no path through
    // the case below can leave one unassigned and infer a latch.
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sig_d   = sig_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    opc_d   = opc_q;

    unique case (state_q)
      S_IDLE: begin
        // in_valid alongside an accepted start is deliberately not absorbed.
        if (bus.start) begin
          len_d  = bus.len;
          sig_d  = SEED;
          cnt_d  = '0;
          ones_d = '0;
          opc_d  = '0;
          if (bus.len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        // op/q are only looked at under in_valid so X on them when idle
        // cannot reach state.
        if (bus.in_valid) begin
          sig_d         = {sig_q[WIDTH-2:0], fb} ^ bus.q;
          cnt_d         = cnt_q + CNT_W'(1);
          ones_d        = ones_q + popcount(bus.q);
          opc_d[bus.op] = opc_q[bus.op] + CNT_W'(1);
          if (cnt_d == len_q) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= SEED;
      len_q   <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sig_q   <= sig_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      opc_q   <= opc_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.signature    = sig_q;
  assign bus.sample_count = cnt_q;
  assign bus.ones_total   = ones_q;
  assign bus.op_count0    = opc_q[0];
  assign bus.op_count1    = opc_q[1];
  assign bus.op_count2    = opc_q[2];
  assign bus.op_count3    = opc_q[3];

endmodule
